// File: rtl/router_out_arbiter.sv
// router_out_arbiter: per-output-port switch allocator for the mesh router.
// Round-robin picks one requesting input, holds the grant from head to tail
// flit, and forwards the owner's flits through one registered valid/ready stage.
module router_out_arbiter #(
  parameter int NPORTS = 4,
  parameter int FLIT_W = 16,
  parameter int PTR_W  = $clog2(NPORTS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NPORTS-1:0]        req_i,
  input  logic [NPORTS-1:0]        valid_i,
  input  logic [NPORTS-1:0]        tail_i,
  input  logic [NPORTS*FLIT_W-1:0] flit_i,
  output logic [NPORTS-1:0]        ready_o,
  output logic                     valid_o,
  output logic [FLIT_W-1:0]        flit_o,
  output logic                     tail_o,
  input  logic                     ready_i,
  output logic [NPORTS-1:0]        grant_o,
  output logic                     busy_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam logic [PTR_W:0] NPORTS_W = (PTR_W+1)'(NPORTS);

  // Reduce an index in [0, 2*NPORTS) back into [0, NPORTS).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] v);
    return (v >= NPORTS_W) ? PTR_W'(v - NPORTS_W) : v[PTR_W-1:0];
  endfunction

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   owner_reg, owner_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic               valid_reg;
  logic               tail_reg;
  logic [FLIT_W-1:0]  flit_reg;

  logic [NPORTS-1:0]  cand;
  logic [PTR_W-1:0]   rot_idx [NPORTS];
  logic [NPORTS-1:0]  rot_hit;
  logic [FLIT_W-1:0]  flit_arr [NPORTS];
  logic               hit;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   pick_inc;
  logic               locked;
  logic               xfer;
  logic [FLIT_W-1:0]  own_flit;
  logic               own_tail;

  assign cand   = req_i & valid_i;
  assign locked = (state_reg == ST_LOCKED);

  // rot_hit[k] tells whether the k-th input after the pointer is a candidate;
  // each lane also unpacks its flit and derives its grant/ready bit.
  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_lane
      assign rot_idx[gi]  = wrap_idx({1'b0, ptr_reg} + (PTR_W+1)'(gi));
      assign rot_hit[gi]  = cand[rot_idx[gi]];
      assign flit_arr[gi] = flit_i[gi*FLIT_W +: FLIT_W];
      assign grant_o[gi]  = locked && (owner_reg == PTR_W'(gi));
      assign ready_o[gi]  = grant_o[gi] && (!valid_reg || ready_i);
    end
  endgenerate

  // First candidate at or after the pointer wins; scanning downward lets the
  // lowest rotation distance overwrite any farther hit.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (rot_hit[k]) begin
        hit  = 1'b1;
        pick = rot_idx[k];
      end
    end
  end

  assign pick_inc = wrap_idx({1'b0, pick} + (PTR_W+1)'(1));
  assign own_flit = flit_arr[owner_reg];
  assign own_tail = tail_i[owner_reg];
  assign xfer     = |(ready_o & valid_i);

  // Next-state logic: arbitrate while idle, release after the tail transfers.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (hit) begin
          state_next = ST_LOCKED;
          owner_next = pick;
          ptr_next   = pick_inc;
        end
      end
      ST_LOCKED: begin
        if (xfer && own_tail) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Output stage: load on transfer, drain on downstream pop, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      flit_reg  <= '0;
      tail_reg  <= 1'b0;
    end else if (xfer) begin
      valid_reg <= 1'b1;
      flit_reg  <= own_flit;
      tail_reg  <= own_tail;
    end else if (valid_reg && ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid_o = valid_reg;
  assign flit_o  = flit_reg;
  assign tail_o  = tail_reg;
  assign busy_o  = locked;

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port switch allocator and output register for the Dally mesh router. It sits directly downstream of the route-computation blocks. Each input port's route-compute stage raises one of its outputs (NS, WE, Diag or Self), and that line drives one `req_i` bit of the matching output port's arbiter. The block grants one input by round-robin and locks the grant for the whole packet (head to tail flit). It then forwards flits through a single registered stage with valid/ready flow control.

## Interface
Parameters:
- `NPORTS`, 4: number of competing input ports.
- `FLIT_W`, 16: flit payload width in bits.
- `PTR_W`, `$clog2(NPORTS)`: width of the round-robin pointer and owner index (derived).

Ports:
- `clk_i`  in  1  clock. One clock; everything is rising-edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_i`  in  NPORTS  bit i: input i's route-compute says its head flit targets this output.
- `valid_i`  in  NPORTS  bit i: input i presents a flit.
- `tail_i`  in  NPORTS  bit i: the flit presented by input i is the last of its packet.
- `flit_i`  in  NPORTS*FLIT_W  flits, input i at bits [i*FLIT_W +: FLIT_W].
- `ready_o`  out  NPORTS  bit i: this block accepts input i's flit this cycle.
- `valid_o`  out  1  output register holds a flit.
- `flit_o`  out  FLIT_W  registered flit.
- `tail_o`  out  1  registered tail flag.
- `ready_i`  in  1  downstream accepts `flit_o`.
- `grant_o`  out  NPORTS  one-hot current owner; all zero when IDLE.
- `busy_o`  out  1  high while LOCKED.

## Operation
- The FSM has two states, IDLE and LOCKED. Registered state: `state`, `owner` (PTR_W), `ptr` (PTR_W), and the output register (`valid_o`, `flit_o`, `tail_o`).
- Candidate set in IDLE: `cand = req_i & valid_i`.
- IDLE arbitration:
  - Search `cand` in the order ptr, ptr+1, …, NPORTS-1, 0, …, ptr-1. Indices wrap modulo NPORTS.
  - First hit g: next cycle `state`=LOCKED, `owner`=g, `ptr`=(g+1) mod NPORTS.
  - No hit: remain IDLE, `ptr` unchanged.
- `ready_o` is all zero in IDLE.
- In LOCKED, only the owner is served:
  - `ready_o[owner] = !valid_o || ready_i`.
  - All other `ready_o` bits are 0.
- `req_i` is ignored in LOCKED. The lock persists until the tail flit transfers, even if the owner's `req_i` drops.
- Transfer: `valid_i[owner] && ready_o[owner]`. On transfer, `flit_o`←`flit_i[owner]`, `tail_o`←`tail_i[owner]`, and `valid_o`←1.
- A transfer with `tail_i[owner]`=1 returns the FSM to IDLE next cycle. A single-flit packet (head=tail) is legal.
- Output register when there is no transfer:
  - If `valid_o && ready_i`, `valid_o`←0.
  - Otherwise hold. `flit_o`/`tail_o` stay stable while `valid_o && !ready_i`.
- `grant_o` = one-hot(`owner`) when LOCKED, 0 when IDLE. `busy_o` = (state==LOCKED).

## Timing
- Reset (`rst_ni`=0 at a clock edge) gives state IDLE, `owner`=0, `ptr`=0, `valid_o`=0, `flit_o`=0, `tail_o`=0. Combinationally this gives `grant_o`=0, `busy_o`=0, `ready_o`=0.
- Reset mid-packet drops the lock and any flit held in the output register. No recovery is attempted.
- Arbitration latency:
  - `cand` seen in cycle t gives `grant_o`/`busy_o` in t+1.
  - The earliest head acceptance is t+1.
  - The head flit appears on `valid_o` in t+2.
- Throughput: with `ready_i` held at 1, one flit per cycle is sustained within a packet.
- Tail turnaround:
  - The tail transfers in cycle c, and the block is IDLE in c+1.
  - A new grant appears in c+2.
  - This one-cycle bubble between packets is required behaviour.
- Backpressure: if `ready_i`=0 while `valid_o`=1, `ready_o[owner]` falls to 0 in the same cycle (combinational) and the held flit is stable.
- Simultaneous events:
  - Downstream pop and owner push in the same cycle: the register reloads with no bubble.
  - Multiple candidates in IDLE: only one is granted; the others wait with `ready_o`=0.

## Test plan
- Single request: `req_i`=4'b0100 with `valid_i[2]`=1 and a 3-flit packet (A,B,C with tail on C), `ready_i`=1.
  - Expect `grant_o`=4'b0100 one cycle later.
  - Expect `flit_o` = A, B, C on consecutive cycles with `tail_o`=1 on C.
  - Expect IDLE afterwards, with `ptr`=3.
- Round-robin fairness: all four inputs continuously request single-flit packets, starting from `ptr`=0.
  - Expect grant order 0,1,2,3,0, with one idle cycle between grants.
- Lock hold: input 1 is granted, then `req_i[3]` rises mid-packet.
  - Expect `ready_o[3]`=0 until input 1's tail transfers.
  - Expect input 3 to be granted two cycles after that tail.
- Backpressure: hold `ready_i`=0 for 3 cycles with `valid_o`=1.
  - Expect `flit_o` stable and `ready_o`=0 throughout.
  - After `ready_i` returns to 1, expect no flit loss or duplication.
- Reset mid-packet: assert `rst_ni`=0 for one cycle after flit 1 of a 4-flit packet.
  - Expect all outputs zero and IDLE next cycle, with `ptr`=0.
- Wrap-around: `ptr`=3 and `cand`=4'b0011.
  - Expect grant to input 0 and `ptr`←1.
